// File: rtl/uart_rx_sampler.sv
// Oversampling front end of the UART receiver: line synchroniser, edge/bit
// counters and a 3-sample majority vote taken around each bit centre.
module uart_rx_sampler #(
    parameter int FRAME_BITS = 11
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       RX_IN,
    input  logic       cnt_en,
    input  logic [5:0] Prescale,
    output logic       rx_sync,
    output logic [5:0] edge_cnt,
    output logic [3:0] bit_cnt,
    output logic       sampled_bit,
    output logic       sample_valid,
    output logic       frame_end
);

    localparam logic [3:0] LAST_BIT = 4'(FRAME_BITS - 1);

    logic       sync1_reg, sync2_reg;
    logic [5:0] p_reg, p_next;
    logic [5:0] edge_reg, edge_next;
    logic [3:0] bit_reg, bit_next;
    logic       s0_reg, s0_next;
    logic       s1_reg, s1_next;
    logic       sampled_reg, sampled_next;
    logic       valid_reg, valid_next;
    logic       fe_reg, fe_next;
    logic [5:0] half;
    logic       edge_last;
    logic       vote;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync1_reg <= 1'b1;
            sync2_reg <= 1'b1;
        end else begin
            sync1_reg <= RX_IN;
            sync2_reg <= sync1_reg;
        end
    end

    assign half      = {1'b0, p_reg[5:1]};
    assign edge_last = (edge_reg == p_reg - 6'd1);
    // The third sample is taken straight from the line so the vote can be
    // registered in the same edge that would have captured it.
    assign vote      = (s0_reg & s1_reg) | (s0_reg & sync2_reg) | (s1_reg & sync2_reg);

    always_comb begin
        p_next       = p_reg;
        edge_next    = 6'd0;
        bit_next     = 4'd0;
        s0_next      = s0_reg;
        s1_next      = s1_reg;
        sampled_next = sampled_reg;
        valid_next   = 1'b0;
        fe_next      = 1'b0;
        if (!cnt_en) begin
            if (Prescale == 6'd8 || Prescale == 6'd16 || Prescale == 6'd32)
                p_next = Prescale;
            else
                p_next = 6'd8;
        end else begin
            if (edge_last) begin
                edge_next = 6'd0;
                bit_next  = (bit_reg == LAST_BIT) ? 4'd0 : bit_reg + 4'd1;
                fe_next   = (bit_reg == LAST_BIT);
            end else begin
                edge_next = edge_reg + 6'd1;
                bit_next  = bit_reg;
            end
            if (edge_reg == half - 6'd1)
                s0_next = sync2_reg;
            if (edge_reg == half)
                s1_next = sync2_reg;
            if (edge_reg == half + 6'd1) begin
                sampled_next = vote;
                valid_next   = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            p_reg       <= 6'd8;
            edge_reg    <= 6'd0;
            bit_reg     <= 4'd0;
            s0_reg      <= 1'b1;
            s1_reg      <= 1'b1;
            sampled_reg <= 1'b1;
            valid_reg   <= 1'b0;
            fe_reg      <= 1'b0;
        end else begin
            p_reg       <= p_next;
            edge_reg    <= edge_next;
            bit_reg     <= bit_next;
            s0_reg      <= s0_next;
            s1_reg      <= s1_next;
            sampled_reg <= sampled_next;
            valid_reg   <= valid_next;
            fe_reg      <= fe_next;
        end
    end

    assign rx_sync      = sync2_reg;
    assign edge_cnt     = edge_reg;
    assign bit_cnt      = bit_reg;
    assign sampled_bit  = sampled_reg;
    assign sample_valid = valid_reg;
    assign frame_end    = fe_reg;

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Bench for uart_rx_sampler: directed scenarios plus randomized frames, all
// checked every cycle against a run-length based reference model.
module tb_uart_rx_sampler;

    localparam int FB = 11;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       RX_IN = 1'b0;
    logic       cnt_en = 1'b0;
    logic [5:0] Prescale = 6'd8;
    logic       rx_sync;
    logic [5:0] edge_cnt;
    logic [3:0] bit_cnt;
    logic       sampled_bit;
    logic       sample_valid;
    logic       frame_end;

    uart_rx_sampler #(.FRAME_BITS(FB)) dut (
        .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .cnt_en(cnt_en), .Prescale(Prescale),
        .rx_sync(rx_sync), .edge_cnt(edge_cnt), .bit_cnt(bit_cnt),
        .sampled_bit(sampled_bit), .sample_valid(sample_valid), .frame_end(frame_end)
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;

    // Reference model: run = consecutive enabled cycles since counting began.
    int   run;
    int   last_p;
    bit   m_sampled;
    bit   hist[$];
    bit   got_bits[$];
    int   fe_count;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int legal(input int p);
        return (p == 8 || p == 16 || p == 32) ? p : 8;
    endfunction

    function automatic logic [5:0] pick_prescale();
        case ($urandom_range(0, 3))
            0:       return 6'd8;
            1:       return 6'd16;
            2:       return 6'd32;
            default: return 6'($urandom_range(0, 63));
        endcase
    endfunction

    task automatic model_reset();
        run = 0;
        last_p = 8;
        m_sampled = 1'b1;
        hist.delete();
        hist.push_back(1'b1);
        hist.push_back(1'b1);
    endtask

    task automatic compare_all();
        int e, b;
        bit v, f;
        e = run % last_p;
        b = (run / last_p) % FB;
        v = (run > 0) && (e == last_p / 2 + 2);
        f = (run > 0) && (run % (last_p * FB) == 0);
        check("rx_sync", 32'(rx_sync), 32'(hist[hist.size() - 2]));
        check("edge_cnt", 32'(edge_cnt), 32'(e));
        check("bit_cnt", 32'(bit_cnt), 32'(b));
        check("sample_valid", 32'(sample_valid), 32'(v));
        check("frame_end", 32'(frame_end), 32'(f));
        check("sampled_bit", 32'(sampled_bit), 32'(m_sampled));
    endtask

    task automatic step();
        int n;
        @(posedge CLK);
        if (RST) begin
            model_reset();
        end else begin
            hist.push_back(RX_IN);
            if (hist.size() > 8) void'(hist.pop_front());
            if (cnt_en) begin
                run++;
            end else begin
                run = 0;
                last_p = legal(int'(Prescale));
            end
            if (run > 0 && (run % last_p) == last_p / 2 + 2) begin
                n = hist.size();
                m_sampled = (int'(hist[n-3]) + int'(hist[n-4]) + int'(hist[n-5])) >= 2;
            end
        end
        @(negedge CLK);
        compare_all();
        if (sample_valid === 1'b1) begin
            got_bits.push_back(sampled_bit);
            $display("sample: bit_cnt=%0d edge_cnt=%0d sampled_bit=%0d", bit_cnt, edge_cnt, sampled_bit);
        end
        if (frame_end === 1'b1) begin
            fe_count++;
            $display("frame_end at t=%0t", $time);
        end
    endtask

    task automatic async_reset();
        #2;
        RST = 1'b1;
        #1;
        model_reset();
        compare_all();
        step();
        RST = 1'b0;
    endtask

    int exp_seq[11] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 0, 1};
    logic [10:0] frame;
    int   max_edge;
    int   nvalid;
    bit   held;
    bit   bitval;
    int   len;

    initial begin
        model_reset();
        fe_count = 0;
        // Reset with line low: syncs must read 1 until release.
        #1 RST = 1'b1;
        #1 compare_all();
        check("rst_sampled", 32'(sampled_bit), 32'd1);
        step();
        step();
        @(negedge CLK);
        RST = 1'b0;
        step();
        step();
        check("rx_sync_after_2", 32'(rx_sync), 32'd0);

        // P=8 frame: start 0, data 0xA5 LSB-first, parity 0, stop 1.
        frame = {1'b1, 1'b0, 8'hA5, 1'b0};
        Prescale = 6'd8;
        RX_IN = 1'b1;
        step();
        got_bits.delete();
        fe_count = 0;
        cnt_en = 1'b1;
        for (int t = 0; t < 8 * FB + 2; t++) begin
            RX_IN = (t < 8 * FB) ? frame[t / 8] : 1'b1;
            step();
        end
        check("frame_nbits", 32'(got_bits.size()), 32'd11);
        for (int i = 0; i < 11 && i < got_bits.size(); i++)
            check($sformatf("frame_bit%0d", i), 32'(got_bits[i]), 32'(exp_seq[i]));
        check("frame_end_count", 32'(fe_count), 32'd1);

        // P=16 glitch rejection and mid-frame prescale change to 32.
        cnt_en = 1'b0;
        Prescale = 6'd16;
        RX_IN = 1'b0;
        step();
        got_bits.delete();
        cnt_en = 1'b1;
        for (int t = 0; t < 48; t++) begin
            if (t < 16)      RX_IN = ((t % 16) == 6);
            else if (t < 32) RX_IN = ((t % 16) == 5) || ((t % 16) == 7);
            else             RX_IN = 1'b0;
            if (t == 20) Prescale = 6'd32;
            step();
        end
        check("glitch_nbits", 32'(got_bits.size()), 32'd3);
        if (got_bits.size() >= 2) begin
            check("glitch_single", 32'(got_bits[0]), 32'd0);
            check("glitch_double", 32'(got_bits[1]), 32'd1);
        end

        // cnt_en dropped at edge 5 of a P=16 bit.
        cnt_en = 1'b0;
        Prescale = 6'd16;
        RX_IN = 1'b0;
        step();
        cnt_en = 1'b1;
        repeat (5) step();
        check("drop_edge5", 32'(edge_cnt), 32'd5);
        held = sampled_bit;
        nvalid = got_bits.size();
        cnt_en = 1'b0;
        step();
        check("drop_edge0", 32'(edge_cnt), 32'd0);
        check("drop_bit0", 32'(bit_cnt), 32'd0);
        repeat (4) step();
        check("drop_novalid", 32'(got_bits.size()), 32'(nvalid));
        check("drop_held", 32'(sampled_bit), 32'(held));

        // Illegal prescale 20 behaves as 8.
        Prescale = 6'd20;
        step();
        cnt_en = 1'b1;
        max_edge = 0;
        for (int t = 0; t < 30; t++) begin
            RX_IN = 6'(t) < 6'd4;
            step();
            if (int'(edge_cnt) > max_edge) max_edge = int'(edge_cnt);
        end
        check("p20_max_edge", 32'(max_edge), 32'd7);

        // Async reset at bit 4, edge 3, then resume with cnt_en held high.
        cnt_en = 1'b0;
        Prescale = 6'd8;
        step();
        cnt_en = 1'b1;
        repeat (35) step();
        check("pre_rst_bit", 32'(bit_cnt), 32'd4);
        check("pre_rst_edge", 32'(edge_cnt), 32'd3);
        async_reset();
        check("rst_edge0", 32'(edge_cnt), 32'd0);
        for (int t = 1; t <= 3; t++) begin
            step();
            check("restart_edge", 32'(edge_cnt), 32'(t));
            check("restart_bit", 32'(bit_cnt), 32'd0);
        end

        // Randomized enable runs, prescales, line levels and glitches.
        for (int r = 0; r < 40; r++) begin
            got_bits.delete();
            cnt_en = 1'b0;
            Prescale = pick_prescale();
            RX_IN = 1'b1;
            repeat ($urandom_range(1, 3)) step();
            len = $urandom_range(1, 400);
            cnt_en = 1'b1;
            bitval = 1'b0;
            for (int t = 0; t < len; t++) begin
                if ((t % 8) == 0) bitval = 1'($urandom_range(0, 1));
                RX_IN = bitval ^ ($urandom_range(0, 15) == 0);
                if ($urandom_range(0, 99) == 0) Prescale = pick_prescale();
                step();
            end
            if ($urandom_range(0, 7) == 0) async_reset();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
